// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing, derived sync window bounds and shared types
// for the VGA sync stage.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  // Control bits that travel alongside the upstream pixel pipeline.
  typedef struct packed {
    logic hs;
    logic vs;
    logic req;
  } ctrl_t;

  function automatic logic sync_level(input logic asserted, input bit pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register with async active-low clear; DEPTH=0 is a wire.
module sync_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_regs
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_565.sv
// VGA timing generator: requests pixel coordinates upstream and emits
// DE-aligned RGB565 with syncs delayed to match the upstream latency.
module vga_sync_565
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_DLY = 1,
  parameter int CNT_W    = 10
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEn,
  input  logic [15:0]      iRGB_565,
  output logic [CNT_W-1:0] oX,
  output logic [CNT_W-1:0] oY,
  output logic             oReq,
  output logic             oHSync,
  output logic             oVSync,
  output logic             oDE,
  output logic [15:0]      oRGB_565,
  output logic             oFrameStart
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
    $error("vga_sync_565: H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W bits");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
    $error("vga_sync_565: PIPE_DLY must lie in 0..7");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(HS_END);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(VS_START);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(VS_END);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             first_tick;
  logic             at_last;
  ctrl_t            ctrl_raw, ctrl_dly;

  assign at_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (iEn) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // The first enabled tick after reset counts as a frame origin as well as
  // every tick that wraps the counters back to 0,0.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      first_tick  <= 1'b1;
      oFrameStart <= 1'b0;
    end else begin
      oFrameStart <= iEn && (first_tick || at_last);
      if (iEn) first_tick <= 1'b0;
    end
  end

  assign oX   = h_cnt;
  assign oY   = v_cnt;
  assign oReq = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);

  always_comb begin
    ctrl_raw     = '0;
    ctrl_raw.hs  = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
    ctrl_raw.vs  = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);
    ctrl_raw.req = oReq;
  end

  sync_delay_line #(
    .DEPTH (PIPE_DLY),
    .WIDTH ($bits(ctrl_t))
  ) u_ctrl_dly (
    .clk   (iClk),
    .rst_n (iRst_n),
    .en    (iEn),
    .d     (ctrl_raw),
    .q     (ctrl_dly)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oDE      <= 1'b0;
      oHSync   <= ~SYNC_POL;
      oVSync   <= ~SYNC_POL;
      oRGB_565 <= RGB565_BLACK;
    end else if (iEn) begin
      oDE      <= ctrl_dly.req;
      oHSync   <= sync_level(ctrl_dly.hs, SYNC_POL);
      oVSync   <= sync_level(ctrl_dly.vs, SYNC_POL);
      oRGB_565 <= ctrl_dly.req ? iRGB_565 : RGB565_BLACK;
    end
  end

endmodule

// File: tb/tb_vga_sync_565.sv
// Scoreboard bench for vga_sync_565 on a reduced raster, with three
// instances at PIPE_DLY 0, 1 and 3 sharing clock, enable and reset.
module tb_vga_sync_565;

  localparam int HA = 20, HF = 4, HS = 6, HB = 5;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NI = 3;

  typedef struct {
    int x;
    int y;
    bit de;
    bit hs;
    bit vs;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic white = 1'b0;

  logic [9:0]  ox   [NI];
  logic [9:0]  oy   [NI];
  logic        oreq [NI];
  logic        ohs  [NI];
  logic        ovs  [NI];
  logic        ode  [NI];
  logic        ofs  [NI];
  logic [15:0] orgb [NI];
  logic [15:0] irgb [NI];

  int    n_compared = 0;
  int    n_mismatched = 0;
  int    cycle = 0;
  int    last_fs = -1;
  int    period_exp = 0;
  int    h = 0;
  int    v = 0;
  bit    first_tick = 1'b1;
  item_t q[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] pixel_of(input logic [9:0] x, input logic [9:0] y);
    return {y[4:0], x[5:0], x[4:0]};
  endfunction

  function automatic int dly_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  // Each instance gets its own upstream renderer model with matching latency.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    logic [15:0] pp [8];

    always @(posedge clk) begin
      if (en) begin
        pp[0] <= pixel_of(ox[g], oy[g]);
        for (int k = 1; k < 8; k++) pp[k] <= pp[k-1];
      end
    end

    assign irgb[g] = white ? 16'hFFFF :
                     (D == 0) ? pixel_of(ox[g], oy[g]) : pp[(D == 0) ? 0 : D - 1];

    vga_sync_565 #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .SYNC_POL (1'b0), .PIPE_DLY (D), .CNT_W (10)
    ) dut (
      .iClk        (clk),
      .iRst_n      (rst_n),
      .iEn         (en),
      .iRGB_565    (irgb[g]),
      .oX          (ox[g]),
      .oY          (oy[g]),
      .oReq        (oreq[g]),
      .oHSync      (ohs[g]),
      .oVSync      (ovs[g]),
      .oDE         (ode[g]),
      .oRGB_565    (orgb[g]),
      .oFrameStart (ofs[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s @cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic checkReset();
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("rst_oX%0d", i), 32'(ox[i]), 0);
      checkOutput($sformatf("rst_oY%0d", i), 32'(oy[i]), 0);
      checkOutput($sformatf("rst_oReq%0d", i), 32'(oreq[i]), 1);
      checkOutput($sformatf("rst_oHSync%0d", i), 32'(ohs[i]), 1);
      checkOutput($sformatf("rst_oVSync%0d", i), 32'(ovs[i]), 1);
      checkOutput($sformatf("rst_oDE%0d", i), 32'(ode[i]), 0);
      checkOutput($sformatf("rst_oRGB%0d", i), 32'(orgb[i]), 0);
      checkOutput($sformatf("rst_oFrameStart%0d", i), 32'(ofs[i]), 0);
    end
  endtask

  task automatic checkItem(input int i, input logic fs_exp);
    item_t e;
    int    d;
    logic [15:0] rgb_exp;
    d = dly_of(i);
    if (q.size() > d) begin
      e = q[d];
    end else begin
      e.x = 0; e.y = 0; e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
    end
    rgb_exp = e.de ? (white ? 16'hFFFF : pixel_of(10'(e.x), 10'(e.y))) : 16'h0000;
    checkOutput($sformatf("oDE%0d", i), 32'(ode[i]), 32'(e.de));
    checkOutput($sformatf("oHSync%0d", i), 32'(ohs[i]), e.hs ? 0 : 1);
    checkOutput($sformatf("oVSync%0d", i), 32'(ovs[i]), e.vs ? 0 : 1);
    checkOutput($sformatf("oRGB%0d", i), 32'(orgb[i]), 32'(rgb_exp));
    checkOutput($sformatf("oFrameStart%0d", i), 32'(ofs[i]), 32'(fs_exp));
  endtask

  // One iClk cycle: check the request stage, push the expectation for this
  // tick, clock, then compare every instance against its delayed entry.
  task automatic applyStimulus(input logic en_val);
    item_t it;
    logic  fs_next;
    en = en_val;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("oX%0d", i), 32'(ox[i]), h);
      checkOutput($sformatf("oY%0d", i), 32'(oy[i]), v);
      checkOutput($sformatf("oReq%0d", i), 32'(oreq[i]), ((h < HA) && (v < VA)) ? 1 : 0);
    end
    fs_next = 1'b0;
    if (en_val) begin
      it.x  = h;
      it.y  = v;
      it.de = (h < HA) && (v < VA);
      it.hs = (h >= HA + HF) && (h < HA + HF + HS);
      it.vs = (v >= VA + VF) && (v < VA + VF + VS);
      q.push_front(it);
      if (q.size() > 4) void'(q.pop_back());
      fs_next = first_tick || ((h == HT - 1) && (v == VT - 1));
      first_tick = 1'b0;
      if (h == HT - 1) begin
        h = 0;
        v = (v == VT - 1) ? 0 : v + 1;
      end else begin
        h++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
    for (int i = 0; i < NI; i++) checkItem(i, fs_next);
    if (ofs[0] === 1'b1) begin
      if (period_exp != 0 && last_fs >= 0)
        checkOutput("frame_period", cycle - last_fs, period_exp);
      last_fs = cycle;
    end
  endtask

  task automatic resetModel();
    q.delete();
    h = 0;
    v = 0;
    first_tick = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    en    = 1'b1;
    white = 1'b0;
    resetModel();
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkReset();
    end
    rst_n = 1'b1;

    repeat (20) applyStimulus(1'b1);

    period_exp = HT * VT;
    last_fs = -1;
    repeat (2 * HT * VT) applyStimulus(1'b1);

    white = 1'b1;
    repeat (HT * VT) applyStimulus(1'b1);
    white = 1'b0;

    period_exp = 2 * HT * VT;
    last_fs = -1;
    for (int k = 0; k < 4 * HT * VT + 10; k++) applyStimulus((k % 2) == 0);

    period_exp = 0;
    last_fs = -1;
    guard = 0;
    while (!((h == 12) && (v == 4)) && guard < 2000) begin
      applyStimulus(1'b1);
      guard++;
    end
    checkOutput("reach_midframe", ((h == 12) && (v == 4)) ? 1 : 0, 1);

    #2 rst_n = 1'b0;
    #1 checkReset();
    resetModel();
    @(posedge clk);
    @(negedge clk);
    checkReset();
    rst_n = 1'b1;
    repeat (HT * VT + 40) applyStimulus(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/vga_sync_565.md
Name: vga_sync_565

Overview:
- Display timing stage directly downstream of the 1-bit-to-RGB565 colour expander.
- Generates VGA horizontal and vertical counters, sync pulses and data-enable.
- Issues pixel coordinates upstream to the renderer and colour expander, and takes back the RGB565 pixel after a fixed pipeline delay.
- Emits DE-aligned RGB565 that is forced black in blanking, for the DAC or LCD pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, asserted sync level (0 = active-low)
- PIPE_DLY, 1, upstream latency in enabled ticks (coordinate to iRGB_565 valid), range 0..7
- CNT_W, 10, counter and coordinate width

Ports:
- iClk  in  1  system clock
- iRst_n  in  1  asynchronous active-low reset
- iEn  in  1  pixel-tick enable; all state advances only when 1
- iRGB_565  in  16  pixel from colour expander for the coordinate issued PIPE_DLY ticks earlier
- oX  out  CNT_W  horizontal coordinate being requested
- oY  out  CNT_W  vertical coordinate being requested
- oReq  out  1  oX/oY lie inside the active area
- oHSync  out  1  horizontal sync, pipeline-aligned
- oVSync  out  1  vertical sync, pipeline-aligned
- oDE  out  1  active video, pipeline-aligned
- oRGB_565  out  16  output pixel, 0 when oDE=0
- oFrameStart  out  1  one-iClk pulse at frame origin

Behaviour:
- Clock and reset: one clock, iClk. Reset iRst_n is asynchronous, active-low.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Line order: active, front porch, sync, back porch.
- hCnt: 0..H_TOTAL-1. On an iEn tick at H_TOTAL-1 it wraps to 0 and vCnt increments.
- vCnt: wraps H_TOTAL-1/V_TOTAL-1 → 0/0 on the same tick.
- iEn=0: every register holds; no output changes.
- Request stage (combinational from counters): oX=hCnt, oY=vCnt, oReq=(hCnt<H_ACTIVE)&&(vCnt<V_ACTIVE).
- Raw sync terms:
  - hs_raw asserted when H_ACTIVE+H_FP ≤ hCnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw asserted when V_ACTIVE+V_FP ≤ vCnt < V_ACTIVE+V_FP+V_SYNC.
- Alignment: {hs_raw, vs_raw, oReq} pass through a PIPE_DLY-deep delay line clocked on iEn. PIPE_DLY=0 means a direct wire.
- Output register (on iEn):
  - oDE ← delayed req.
  - oHSync/oVSync ← delayed raw term, mapped to SYNC_POL when asserted and ~SYNC_POL otherwise.
  - oRGB_565 ← delayed req ? iRGB_565 : 16'h0000.
- Total latency: coordinate to output is PIPE_DLY+1 enabled ticks.
- oFrameStart: high for exactly one iClk cycle, the cycle after an iEn tick that makes hCnt=vCnt=0, including the first tick after reset.
- Reset values:
  - Counters 0, delay line cleared to deasserted.
  - oDE=0, oRGB_565=0, oFrameStart=0, oHSync=oVSync=~SYNC_POL.
  - oX=oY=0, oReq=1.
- Reset mid-frame: all of the above apply immediately. Counting resumes from 0,0 on the first iEn after release. No partial sync pulse is stretched.
- Arithmetic: comparisons are unsigned, CNT_W bits. V_TOTAL-1 and H_TOTAL-1 must fit in CNT_W; elaboration error otherwise.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 timing constants;
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - RGB565 black constant.
- One sub-module, sync_delay_line: parameters DEPTH and WIDTH, clock enable, async active-low clear. Used for the 3-bit control pipeline.

Test Plan:
- Reset state: hold iRst_n=0, iEn=1 → oHSync=oVSync=1, oDE=0, oRGB_565=0, oX=oY=0, oReq=1.
- Line timing: iEn=1, PIPE_DLY=1 → oDE high for exactly 640 consecutive cycles per line. Period 800. oHSync low for 96 cycles, starting 16 cycles after oDE falls.
- Frame timing: → oFrameStart pulses every 420000 cycles. oVSync low for exactly 2×800 cycles, starting 10 lines after the last DE line.
- Blanking and alignment: upstream model returns {oY[4:0], oX[5:0], oX[4:0]} after PIPE_DLY ticks; sweep PIPE_DLY=0,1,3 → every DE pixel matches its coordinate, and oRGB_565=0 whenever oDE=0 with iRGB_565=16'hFFFF forced.
- Enable gating: iEn toggles 1,0,1,0 → all timings double in iClk cycles, outputs frozen on iEn=0 cycles, oFrameStart still one iClk wide.
- Reset mid-frame: assert iRst_n at hCnt=300, vCnt=200 → outputs return to reset values asynchronously. After release, the first oFrameStart comes 1 cycle after the first iEn tick.
